// File: rtl/cpu_mem_pkg.sv
// Shared memory-port scheduler types: IorD codes, FSM states, owners.
// Imported by the scheduler, its interface users and its counter.
package cpu_mem_pkg;

    localparam logic [2:0] IORD_PC  = 3'b000;
    localparam logic [2:0] IORD_EXC = 3'b001;
    localparam logic [2:0] IORD_ALU = 3'b010;
    localparam logic [2:0] IORD_RES = 3'b011;
    localparam logic [2:0] IORD_B   = 3'b100;

    localparam logic [2:0] OWN_NONE  = 3'b000;
    localparam logic [2:0] OWN_EXC   = 3'b100;
    localparam logic [2:0] OWN_DATA  = 3'b010;
    localparam logic [2:0] OWN_FETCH = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } sched_state_e;

    function automatic logic sel_legal(input logic [2:0] s);
        return s inside {IORD_ALU, IORD_RES, IORD_B};
    endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester/scheduler bundle for the shared memory port.
// slave = scheduler side, master = requester side.
interface mem_port_sched_if;

    logic       req_exc;
    logic       req_data;
    logic       data_we;
    logic [2:0] data_sel;
    logic       req_fetch;
    logic [2:0] iord_sel;
    logic       mem_wr;
    logic [2:0] grant;
    logic       done_exc;
    logic       done_data;
    logic       done_fetch;
    logic       mem_busy;
    logic       sel_err;

    modport slave (
        input  req_exc, req_data, data_we, data_sel, req_fetch,
        output iord_sel, mem_wr, grant,
        output done_exc, done_data, done_fetch,
        output mem_busy, sel_err
    );

    modport master (
        output req_exc, req_data, data_we, data_sel, req_fetch,
        input  iord_sel, mem_wr, grant,
        input  done_exc, done_data, done_fetch,
        input  mem_busy, sel_err
    );

endinterface

// File: rtl/mem_port_sched_wait_cnt.sv
// Loadable wait-state down-counter; tc flags the last wait cycle.
// Module name mem_wait_cnt, instantiated by mem_port_sched.
module mem_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_sched.sv
// Shared memory-port scheduler: exc > data > fetch, fixed latency.
// MEM_SCHED_RR_EN: data/fetch round-robin behind exc.
module mem_port_sched #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input logic          clk,
    input logic          reset_n,
    mem_port_sched_if.slave bus
);

    import cpu_mem_pkg::*;

    sched_state_e state_q, state_d;
    logic [2:0]   grant_q, grant_d;
    logic [2:0]   iord_q, iord_d;
    logic [2:0]   done_q, done_d;
    logic         mem_wr_q, mem_wr_d;
    logic         busy_q, busy_d;
    logic         sel_err_q, sel_err_d;
    logic [2:0]   win;
    logic [2:0]   data_code;
    logic         sel_ok;
    logic         pick_fetch;
    logic         cnt_load, cnt_dec, cnt_tc;

`ifdef MEM_SCHED_RR_EN
    logic last_q, last_d;
    assign pick_fetch = last_q;
`else
    assign pick_fetch = 1'b0;
`endif

    assign sel_ok    = sel_legal(bus.data_sel);
    assign data_code = sel_ok ? bus.data_sel : IORD_ALU;

    // Pick the requester that would win this IDLE cycle.
    always_comb begin
        win = OWN_NONE;
        if (bus.req_exc) begin
            win = OWN_EXC;
        end else if (bus.req_data && bus.req_fetch) begin
            win = pick_fetch ? OWN_FETCH : OWN_DATA;
        end else if (bus.req_data) begin
            win = OWN_DATA;
        end else if (bus.req_fetch) begin
            win = OWN_FETCH;
        end
    end

    // Next state plus registered outputs for the coming cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        iord_d    = iord_q;
        mem_wr_d  = 1'b0;
        done_d    = 3'b000;
        sel_err_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`ifdef MEM_SCHED_RR_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win != OWN_NONE) begin
                    state_d = ST_ACCESS;
                    grant_d = win;
                    unique case (1'b1)
                        win[2]: iord_d = IORD_EXC;
                        win[1]: begin
                            iord_d    = data_code;
                            mem_wr_d  = bus.data_we;
                            sel_err_d = !sel_ok;
                        end
                        default: iord_d = IORD_PC;
                    endcase
`ifdef MEM_SCHED_RR_EN
                    if (win[1]) last_d = 1'b1;
                    if (win[0]) last_d = 1'b0;
`endif
                end
            end
            ST_ACCESS: begin
                cnt_load = 1'b1;
                if (MEM_LAT > 1) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = OWN_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= OWN_NONE;
            iord_q    <= IORD_PC;
            done_q    <= 3'b000;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            iord_q    <= iord_d;
            done_q    <= done_d;
            mem_wr_q  <= mem_wr_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
        end
    end

`ifdef MEM_SCHED_RR_EN
    // Last data/fetch winner; 0 = fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    mem_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    assign bus.grant      = grant_q;
    assign bus.iord_sel   = iord_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.done_exc   = done_q[2];
    assign bus.done_data  = done_q[1];
    assign bus.done_fetch = done_q[0];
    assign bus.mem_busy   = busy_q;
    assign bus.sel_err    = sel_err_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Testbench for mem_port_sched: timeline model of queued accesses.
// Each batch asks for N accesses per requester, checked per cycle.
module tb_mem_port_sched;

    localparam int LAT = 2;
`ifdef MEM_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_sched_if bus();

    mem_port_sched #(.MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // {grant[11:9], iord[8:6], wr[5], done exc/data/fetch[4:2], busy[1], err[0]}
    logic [11:0] exp_q[$];
    logic        we_a[128];
    logic [2:0]  sel_a[128];
    int          n_e, n_d, n_f;
    bit          last_data;
    logic [2:0]  held_iord;

    function automatic logic [11:0] obs();
        return {bus.grant, bus.iord_sel, bus.mem_wr,
                bus.done_exc, bus.done_data, bus.done_fetch,
                bus.mem_busy, bus.sel_err};
    endfunction

    task automatic check(input string tag, input logic [11:0] o,
                         input logic [11:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 128; i++) begin
            we_a[i]  = 1'($urandom);
            sel_a[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // Lay out the expected cycle-by-cycle timeline for the batch.
    task automatic build();
        int pe = n_e;
        int pd = n_d;
        int pf = n_f;
        int c  = 0;
        logic [2:0] own, code;
        logic wr, err, legal;
        exp_q.delete();
        while (pe + pd + pf > 0) begin
            if (pe > 0)                own = 3'b100;
            else if (pd > 0 && pf > 0) own = (RR && last_data) ? 3'b001 : 3'b010;
            else if (pd > 0)           own = 3'b010;
            else                       own = 3'b001;
            if (own == 3'b010) last_data = 1'b1;
            if (own == 3'b001) last_data = 1'b0;
            legal = (sel_a[c] == 3'd2) || (sel_a[c] == 3'd3) || (sel_a[c] == 3'd4);
            wr  = 1'b0;
            err = 1'b0;
            if (own == 3'b100) code = 3'b001;
            else if (own == 3'b001) code = 3'b000;
            else begin
                code = legal ? sel_a[c] : 3'b010;
                wr   = we_a[c];
                err  = !legal;
            end
            for (int k = 0; k <= LAT; k++)
                exp_q.push_back({own, code, (k == 0) ? wr : 1'b0,
                                 (k == LAT) ? own : 3'b000, 1'b1,
                                 (k == 0) ? err : 1'b0});
            if (own == 3'b100) pe--;
            else if (own == 3'b010) pd--;
            else pf--;
            held_iord = code;
            exp_q.push_back({3'b000, code, 6'b000000});
            c += LAT + 2;
        end
        exp_q.push_back({3'b000, held_iord, 6'b000000});
    endtask

    // Drive requests, check every cycle, drop each request when served out.
    task automatic run_batch(input string tag);
        int re = n_e;
        int rd = n_d;
        int rf = n_f;
        logic [11:0] e;
        build();
        @(negedge clk);
        bus.req_exc   = (re > 0);
        bus.req_data  = (rd > 0);
        bus.req_fetch = (rf > 0);
        bus.data_we   = we_a[0];
        bus.data_sel  = sel_a[0];
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            e = exp_q[c];
            check($sformatf("%s[%0d]", tag, c), obs(), e);
            if (e[4]) begin re--; if (re <= 0) bus.req_exc = 1'b0; end
            if (e[3]) begin rd--; if (rd <= 0) bus.req_data = 1'b0; end
            if (e[2]) begin rf--; if (rf <= 0) bus.req_fetch = 1'b0; end
            bus.data_we  = we_a[c + 1];
            bus.data_sel = sel_a[c + 1];
        end
        bus.req_exc   = 1'b0;
        bus.req_data  = 1'b0;
        bus.req_fetch = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_exc   = 1'b0;
        bus.req_data  = 1'b0;
        bus.req_fetch = 1'b0;
        bus.data_we   = 1'b0;
        bus.data_sel  = 3'b000;
        last_data     = 1'b0;
        held_iord     = 3'b000;
        #1;
        check("reset", obs(), 12'h000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", obs(), 12'h000);

        fill_rand();
        n_e = 0; n_d = 0; n_f = 1;
        run_batch("fetch");

        fill_rand();
        we_a[0] = 1'b1; sel_a[0] = 3'b100;
        n_e = 0; n_d = 1; n_f = 0;
        run_batch("store_b");

        fill_rand();
        n_e = 1; n_d = 1; n_f = 1;
        run_batch("all_three");

        fill_rand();
        we_a[0] = 1'b0; sel_a[0] = 3'b111;
        n_e = 0; n_d = 1; n_f = 0;
        run_batch("bad_sel");

        fill_rand();
        n_e = 0; n_d = 3; n_f = 3;
        run_batch("data_vs_fetch");

        // Reset during the WAIT cycle of a store.
        @(negedge clk);
        bus.req_data = 1'b1;
        bus.data_we  = 1'b1;
        bus.data_sel = 3'b100;
        @(negedge clk);
        check("rst_access", obs(), {3'b010, 3'b100, 1'b1, 3'b000, 1'b1, 1'b0});
        @(posedge clk);
        #2;
        check("rst_wait", obs(), {3'b010, 3'b100, 1'b0, 3'b000, 1'b1, 1'b0});
        reset_n = 1'b0;
        #1;
        check("rst_async", obs(), 12'h000);
        bus.req_data = 1'b0;
        last_data    = 1'b0;
        held_iord    = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check($sformatf("rst_idle[%0d]", i), obs(), 12'h000);
        end

        for (int b = 0; b < 20; b++) begin
            fill_rand();
            n_e = int'($urandom_range(0, 2));
            n_d = int'($urandom_range(0, 2));
            n_f = int'($urandom_range(0, 2));
            run_batch($sformatf("rand%0d", b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Sequences the single shared memory port of the multicycle CPU.
- Arbitrates between three requesters: exception vector fetch, data load/store, and instruction fetch.
- Drives the 3-bit IorD select code, the memory write strobe and per-requester completion pulses.
- Models a fixed-latency synchronous memory by counting wait states.

Parameters:
- MEM_LAT, 2, memory read/write latency in cycles (1..15); the cycle count from address-valid to data-valid.
- CNT_W, 4, width of the wait-state counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_exc  in  1  exception vector fetch request (level, held until done_exc)
- req_data  in  1  data access request (level, held until done_data)
- data_we  in  1  1 = store, 0 = load; sampled at grant
- data_sel  in  3  data address source code: 010 ALU_out, 011 result, 100 B_out
- req_fetch  in  1  instruction fetch request (level, held until done_fetch)
- iord_sel  out  3  IorD select: 000 PC, 001 exception, 010/011/100 per data_sel
- mem_wr  out  1  memory write enable
- grant  out  3  one-hot active owner {exc, data, fetch}
- done_exc, done_data, done_fetch  out  1 each  one-cycle completion pulses
- mem_busy  out  1  high whenever state != IDLE
- sel_err  out  1  one-cycle pulse when an illegal data_sel is captured

Behaviour:
- Reset (async, reset_n=0) forces all of the following immediately:
  - state IDLE, counter 0;
  - iord_sel=000, mem_wr=0, grant=000;
  - all done pulses 0, mem_busy=0, sel_err=0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Sample requests each cycle.
  - Fixed priority: exc > data > fetch.
  - On any request, register the owner, iord code and write flag, then go to ACCESS next cycle.
- ACCESS (1 cycle):
  - grant and iord_sel valid.
  - mem_wr=1 only if owner=data and captured data_we=1.
  - Counter loads MEM_LAT-1.
  - Next state is WAIT if MEM_LAT>1, else DONE.
- WAIT:
  - iord_sel and grant are held; mem_wr=0.
  - Counter decrements each cycle; go to DONE when it reaches 1.
- DONE (1 cycle):
  - The owner's done_* pulses high; iord_sel and grant are still held.
  - Next state IDLE; grant clears on entry to IDLE.
- Latency: request first seen high at cycle n → ACCESS at n+1 → done at n+1+MEM_LAT. Back-to-back accesses re-arbitrate in IDLE, so at least 1 idle cycle separates consecutive grants.
- Outputs are registered; iord_sel holds its last value in IDLE (no glitch to 000 between accesses).
- Write is exactly one cycle per store, regardless of MEM_LAT.
- Boundary conditions:
  - Request dropped mid-access: ignored. The access completes and the done pulse still fires.
  - data_sel, data_we changing after grant: no effect; the values were captured in IDLE.
  - Illegal data_sel (000, 001, 101..111): captured as 010, and sel_err pulses in the ACCESS cycle.
  - Simultaneous requests: only the highest priority is granted. Losers stay pending and are granted in later IDLE cycles.
  - A continuously asserted higher-priority request may starve fetch (see optional feature).
  - Reset asserted mid-access: access aborts with no done pulse, and mem_wr drops immediately.

Optional Feature:
- Macro: MEM_SCHED_RR_EN.
- Defined:
  - exc remains top priority.
  - data and fetch alternate by round-robin: a 1-bit last-winner register (reset = fetch) gives preference to whichever did not win last when both request.
- Undefined: strict exc > data > fetch priority; no last-winner register.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - IorD code constants: IORD_PC=000, IORD_EXC=001, IORD_ALU=010, IORD_RES=011, IORD_B=100;
  - the FSM state enum;
  - owner one-hot constants.
- One natural sub-module: mem_wait_cnt (loadable down-counter with terminal-count flag). The remaining logic stays in mem_port_sched.

Test Plan:
- MEM_LAT=2, req_fetch pulse held → grant=001 and iord_sel=000 at n+1; done_fetch at n+3; mem_busy high for cycles n+1..n+3.
- req_data with data_we=1, data_sel=100 → mem_wr high for exactly 1 cycle at n+1; iord_sel=100; done_data at n+3.
- req_exc, req_data and req_fetch all set at the same cycle → served in order exc (iord 001), data, fetch; each done 1 pulse, with a 1-cycle gap between grants.
- data_sel=111 on a load → iord_sel=010, sel_err pulses once at the ACCESS cycle, mem_wr stays 0.
- reset_n low during WAIT of a store → all outputs zero asynchronously, no done pulse; after release, state IDLE.
- MEM_SCHED_RR_EN defined, req_data and req_fetch held continuously → grants alternate data, fetch, data, fetch; without the macro, data is granted every time.
